// File: rtl/life_engine.sv
`timescale 1ns/1ps
// Game-of-Life (B3/S23) generation engine feeding the LED matrix scanner.
// Define LIFE_TORUS_EN for a wrapping (toroidal) grid; otherwise off-grid neighbours are dead.
module life_engine #(
   parameter int gs     = 8,
   parameter int FRAMES = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [gs*gs-1:0] seed_i,
   input  logic             run_i,
   input  logic             d_disp_i,
   output logic [gs*gs-1:0] matrix_o,
   output logic             e_disp_o,
   output logic             busy_o,
   output logic [15:0]      gen_o
);
   localparam int N  = gs * gs;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
   localparam logic [FW-1:0] FRM_LAST = FW'(FRAMES - 1);

   typedef enum logic [1:0] {GAP, SHOW, COMPUTE, COMMIT} state_t;
   state_t state, state_n;

   logic [N-1:0]  cur, nxt;
   logic [IW-1:0] idx;
   logic [FW-1:0] frm;
   logic          armed;
   logic [15:0]   gen;
   logic [3:0]    n_cnt;
   logic          frame_done, advance;

   // armed masks the scanner's flag left over from the previous frame
   assign frame_done = (state == SHOW) && armed && d_disp_i;
   assign advance    = frame_done && run_i && (frm == FRM_LAST);
   assign matrix_o   = cur;
   assign gen_o      = gen;

   always_comb begin
      int r, c, rr, cc;
      n_cnt = '0;
      r  = int'(idx) / gs;
      c  = int'(idx) % gs;
      rr = 0;
      cc = 0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
`ifdef LIFE_TORUS_EN
               rr = (r + dr + gs) % gs;
               cc = (c + dc + gs) % gs;
               n_cnt = n_cnt + {3'b000, cur[IW'(rr * gs + cc)]};
`else
               rr = r + dr;
               cc = c + dc;
               if (rr >= 0 && rr < gs && cc >= 0 && cc < gs)
                  n_cnt = n_cnt + {3'b000, cur[IW'(rr * gs + cc)]};
`endif
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= GAP;
      else       state <= state_n;
   end

   always_comb begin
      state_n  = state;
      e_disp_o = 1'b0;
      busy_o   = 1'b0;
      case (state)
         GAP:     state_n = SHOW;
         SHOW: begin
            e_disp_o = 1'b1;
            if (frame_done) state_n = advance ? COMPUTE : GAP;
         end
         COMPUTE: begin
            busy_o = 1'b1;
            if (idx == IDX_LAST) state_n = COMMIT;
         end
         COMMIT: begin
            busy_o  = 1'b1;
            state_n = GAP;
         end
         default: state_n = GAP;
      endcase
      if (load_i) state_n = GAP;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cur   <= '0;
         nxt   <= '0;
         idx   <= '0;
         frm   <= '0;
         armed <= 1'b0;
         gen   <= '0;
      end else if (load_i) begin
         cur   <= seed_i;
         gen   <= '0;
         frm   <= '0;
         idx   <= '0;
         armed <= 1'b0;
      end else begin
         armed <= (state == SHOW);
         case (state)
            SHOW: if (frame_done) begin
               if (advance) begin
                  frm <= '0;
                  idx <= '0;
               end else if (frm != FRM_LAST) begin
                  frm <= frm + FW'(1);
               end
            end
            COMPUTE: begin
               nxt[idx] <= (n_cnt == 4'd3) | (cur[idx] & (n_cnt == 4'd2));
               idx      <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end
            COMMIT: begin
               cur <= nxt;
               gen <= gen + 16'd1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_life_engine.sv
`timescale 1ns/1ps
// Scoreboard bench for life_engine: randomized seeds vs. a padded-grid Life model,
// with a scanner model answering the frame handshake.
module tb_life_engine;
   localparam int GS = 8;
   localparam int FR = 16;
   localparam int N  = GS * GS;
   localparam logic [N-1:0] BLINK = 64'h0000_0000_1C00_0000;
   localparam logic [N-1:0] VERT  = 64'h0000_0008_0808_0000;

   typedef struct {
      logic [N-1:0] m;
      logic [15:0]  g;
   } exp_t;

   logic         clk = 1'b0, rst_i = 1'b1, load_i = 1'b0, run_i = 1'b0, d_disp_i = 1'b0;
   logic [N-1:0] seed_i = '0;
   logic [N-1:0] matrix_o;
   logic         e_disp_o, busy_o;
   logic [15:0]  gen_o;

   int   total = 0, bad = 0;
   exp_t sbq[$];
   bit   abort = 1'b0;

   always #5 clk = ~clk;

   life_engine #(.gs(GS), .FRAMES(FR)) dut (
      .clk_i(clk), .rst_i(rst_i), .load_i(load_i), .seed_i(seed_i), .run_i(run_i),
      .d_disp_i(d_disp_i), .matrix_o(matrix_o), .e_disp_o(e_disp_o), .busy_o(busy_o),
      .gen_o(gen_o));

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Next generation from a grid surrounded by a one-cell border (dead, or wrapped copies).
   function automatic logic [N-1:0] life_ref(input logic [N-1:0] g);
      bit p [0:GS+1][0:GS+1];
      logic [N-1:0] o = '0;
      int n;
      for (int r = 0; r < GS + 2; r++)
         for (int c = 0; c < GS + 2; c++) p[r][c] = 1'b0;
      for (int r = 0; r < GS; r++)
         for (int c = 0; c < GS; c++) p[r+1][c+1] = g[6'(GS*r + c)];
`ifdef LIFE_TORUS_EN
      for (int r = 1; r <= GS; r++) begin
         p[r][0]    = p[r][GS];
         p[r][GS+1] = p[r][1];
      end
      for (int c = 0; c < GS + 2; c++) begin
         p[0][c]    = p[GS][c];
         p[GS+1][c] = p[1][c];
      end
`endif
      for (int r = 0; r < GS; r++)
         for (int c = 0; c < GS; c++) begin
            n = 0;
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++) n += int'(p[r+i][c+j]);
            n -= int'(p[r+1][c+1]);
            o[6'(GS*r + c)] = (n == 3) || (p[r+1][c+1] && n == 2);
         end
      return o;
   endfunction

   // Scanner: the flag from the last frame lingers into the next SHOW's first cycle.
   int scnt = 0;
   always @(negedge clk) begin
      if (e_disp_o) begin
         scnt++;
         if (scnt >= GS + 1) d_disp_i = 1'b1;
         else if (scnt >= 2) d_disp_i = 1'b0;
      end else begin
         scnt = 0;
      end
   end

   // Monitor: a commit is a busy high->low without a load in the COMMIT cycle.
   int busy_len = 0, e_len = 0, frames = 0;
   bit p_busy = 0, p_e = 0, p_load = 0, e_intr = 1, run_ok = 1;
   always @(negedge clk) begin
      exp_t x;
      if (rst_i) begin
         busy_len = 0; e_len = 0; frames = 0;
         p_busy = 0; p_e = 0; p_load = 0; e_intr = 1;
      end else begin
         if (abort) begin
            busy_len = 0; frames = 0; p_busy = 0; p_e = 0; e_intr = 1; abort = 0;
         end
         if (!run_i) run_ok = 0;
         if (e_disp_o) begin
            if (!p_e) begin
               e_len = 0; frames++; e_intr = 0;
            end
            e_len++;
         end else if (p_e && !e_intr) begin
            check("show_len", e_len, GS + 1);
         end
         if (busy_o) begin
            busy_len++;
         end else if (p_busy) begin
            check("busy_len", busy_len, N + 1);
            if (!p_load) begin
               if (sbq.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_commit: got gen %0d expected no commit", gen_o);
               end else begin
                  x = sbq.pop_front();
                  check("matrix", matrix_o, x.m);
                  check("gen", gen_o, x.g);
                  if (run_ok) check("frames_per_gen", frames, FR);
               end
               frames = 0;
               run_ok = 1;
            end
            busy_len = 0;
         end
         if (load_i) begin
            frames = 0; run_ok = run_i; e_intr = 1;
         end
         p_busy = busy_o; p_e = e_disp_o; p_load = load_i;
      end
   end

   task automatic do_load(input logic [N-1:0] s, input logic r);
      @(posedge clk); #1;
      seed_i = s; run_i = r; load_i = 1'b1;
      @(posedge clk); #1;
      load_i = 1'b0;
      @(negedge clk);
      check("load_matrix", matrix_o, s);
      check("load_gen", gen_o, 0);
   endtask

   task automatic drain(input int maxc);
      int n = 0;
      while (sbq.size() != 0 && n < maxc) begin
         @(negedge clk);
         n++;
      end
      check("drain", sbq.size(), 0);
   endtask

   task automatic wait_busy(input int maxc, input string nm);
      int n = 0;
      @(negedge clk);
      while (!busy_o && n < maxc) begin
         @(negedge clk);
         n++;
      end
      check(nm, busy_o, 1);
   endtask

   initial begin
      logic [N-1:0] s, g;
      exp_t e;
      int fr, cyc;
      bit bsy, pe;

      repeat (3) @(negedge clk);
      check("rst_matrix", matrix_o, 0);
      check("rst_gen", gen_o, 0);
      check("rst_e_disp", e_disp_o, 0);
      check("rst_busy", busy_o, 0);
      @(posedge clk); #1 rst_i = 1'b0;
      @(negedge clk);
      check("gap_after_rst", e_disp_o, 0);

      // blinker oscillates
      e.m = VERT;  e.g = 16'd1; sbq.push_back(e);
      e.m = BLINK; e.g = 16'd2; sbq.push_back(e);
      do_load(BLINK, 1'b1);
      drain(1000);

      // top-edge blinker
`ifdef LIFE_TORUS_EN
      e.m = 64'h0800_0000_0000_0808;
`else
      e.m = 64'h0000_0000_0000_0808;
`endif
      e.g = 16'd1; sbq.push_back(e);
      do_load(64'h1C, 1'b1);
      drain(500);

      // random seeds, three generations each
      for (int k = 0; k < 6; k++) begin
         s = {$urandom, $urandom};
         g = s;
         for (int j = 1; j <= 3; j++) begin
            g = life_ref(g);
            e.m = g; e.g = 16'(j); sbq.push_back(e);
         end
         do_load(s, 1'b1);
         drain(1000);
      end

      // load lands in the COMMIT cycle and wins
      do_load(BLINK, 1'b1);
      wait_busy(400, "busy_start_prio");
      repeat (N) @(posedge clk);
      #1 seed_i = 64'hFF; load_i = 1'b1;
      @(negedge clk);
      check("commit_cycle_busy", busy_o, 1);
      @(posedge clk); #1 load_i = 1'b0;
      @(negedge clk);
      check("prio_matrix", matrix_o, 64'hFF);
      check("prio_gen", gen_o, 0);
      check("prio_gap", e_disp_o, 0);
      check("prio_not_busy", busy_o, 0);
      @(negedge clk);
      check("prio_show", e_disp_o, 1);

      // hold with run_i low
      do_load(BLINK, 1'b0);
      fr = 0; cyc = 0; bsy = 0; pe = 0;
      while (fr < 100 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (e_disp_o && !pe) fr++;
         pe = e_disp_o;
         if (busy_o) bsy = 1;
      end
      check("hold_frames", fr, 100);
      check("hold_no_compute", bsy, 0);
      check("hold_matrix", matrix_o, BLINK);
      check("hold_gen", gen_o, 0);
      e.m = VERT; e.g = 16'd1; sbq.push_back(e);
      @(posedge clk); #1 run_i = 1'b1;
      wait_busy(30, "run_resume");
      drain(400);

      // async reset in the middle of the next COMPUTE
      wait_busy(400, "busy_start_rst");
      repeat (10) @(negedge clk);
      #2 abort = 1'b1; rst_i = 1'b1;
      #1;
      check("arst_matrix", matrix_o, 0);
      check("arst_gen", gen_o, 0);
      check("arst_busy", busy_o, 0);
      check("arst_e_disp", e_disp_o, 0);
      #1 rst_i = 1'b0; run_i = 1'b0;
      check("arst_gap", e_disp_o, 0);
      @(negedge clk);
      check("arst_show", e_disp_o, 1);
      repeat (5) @(negedge clk);
      check("queue_empty", sbq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
